// File: rtl/mmu_utlb_pkg.sv
// Shared types and constants for the micro-TLB: entry, refill and result records plus FSM states.
package mmu_utlb_pkg;

    localparam int PAGE_OFFSET_W = 12;
    localparam int VPN_W         = 20;
    localparam logic [2:0] CACHE_UNCACHED = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_RESP
    } utlb_state_t;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        logic [7:0]       asid;
        logic             glob;
        logic [VPN_W-1:0] pfn;
        logic             dirty;
        logic [2:0]       cache;
    } utlbEntry_t;

    typedef struct packed {
        logic             miss;
        logic             valid;
        logic             dirty;
        logic             glob;
        logic [2:0]       cache;
        logic [VPN_W-1:0] pfn;
    } utlbRefill_t;

    typedef struct packed {
        logic [31:0] vaddr;
        logic [31:0] paddr;
        logic        miss;
        logic        invalid;
        logic        illegal;
        logic        dirty;
        logic        uncached;
    } mmuResult_t;

    // kuseg, kseg2 and kseg3 go through the TLB; kseg0/kseg1 are direct-mapped.
    function automatic logic is_mapped(input logic [31:0] vaddr);
        return ~vaddr[31] | (vaddr[31:30] == 2'b11);
    endfunction

endpackage

// File: rtl/mmu_utlb_lookup.sv
// Combinational fully-associative match across all micro-TLB entries.
module mmu_utlb_lookup
    import mmu_utlb_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  utlbEntry_t                     entries [ENTRIES],
    input  logic [VPN_W-1:0]               vpn,
    input  logic [7:0]                     asid,
    output logic                           hit,
    output logic [$clog2(ENTRIES)-1:0]     hit_idx,
    output utlbEntry_t                     hit_entry
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] match;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
            assign match[gi] = entries[gi].valid
                             & (entries[gi].vpn == vpn)
                             & (entries[gi].glob | (entries[gi].asid == asid));
        end
    endgenerate

    // At most one entry matches in normal operation; the highest index wins otherwise.
    always_comb begin
        hit       = |match;
        hit_idx   = '0;
        hit_entry = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (match[i]) begin
                hit_idx   = IDX_W'(i);
                hit_entry = entries[i];
            end
        end
    end

endmodule

// File: rtl/mmu_utlb.sv
// Per-channel micro-TLB with segment decode and main-TLB refill handshake.
// Optional performance counters are built when MMU_UTLB_PERF_EN is defined.
module mmu_utlb
    import mmu_utlb_pkg::*;
#(
    parameter int ENTRIES      = 4,
    parameter bit DATA_CHANNEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        asid,
    input  logic              user_mode,
    input  logic              kseg0_uncached,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [31:0]       req_vaddr,
    output logic              req_ready,
    output logic              resp_valid,
    output mmuResult_t        resp_result,
    output logic              refill_req,
    output logic [VPN_W-1:0]  refill_vpn,
    input  logic              refill_ack,
    input  utlbRefill_t       refill_data,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    utlb_state_t      state_q, state_d;
    utlbEntry_t       entries_q [ENTRIES];
    utlbEntry_t       entries_d [ENTRIES];
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [31:0]      pend_vaddr_q, pend_vaddr_d;
    logic             pend_illegal_q, pend_illegal_d;
    logic             pend_flushed_q, pend_flushed_d;
    logic             resp_valid_q, resp_valid_d;
    mmuResult_t       resp_result_q, resp_result_d;

    logic             lu_hit;
    logic [IDX_W-1:0] lu_hit_idx;
    utlbEntry_t       lu_hit_entry;
    logic             req_mapped;
    logic             req_illegal;
    logic             lookup_hit;
    mmuResult_t       unmapped_res, hit_res, refill_res;
    utlbEntry_t       new_entry;
    logic             install;

    mmu_utlb_lookup #(.ENTRIES(ENTRIES)) u_lookup (
        .entries   (entries_q),
        .vpn       (req_vaddr[31:PAGE_OFFSET_W]),
        .asid      (asid),
        .hit       (lu_hit),
        .hit_idx   (lu_hit_idx),
        .hit_entry (lu_hit_entry)
    );

    assign req_mapped  = is_mapped(req_vaddr);
    assign req_illegal = user_mode & req_vaddr[31];
    // A flush in the request cycle makes the array look empty to that lookup.
    assign lookup_hit  = lu_hit & ~flush;

    always_comb begin
        unmapped_res          = '0;
        unmapped_res.vaddr    = req_vaddr;
        unmapped_res.paddr    = {3'b000, req_vaddr[28:0]};
        unmapped_res.illegal  = req_illegal;
        unmapped_res.dirty    = DATA_CHANNEL;
        unmapped_res.uncached = (req_vaddr[31:29] == 3'b101)
                              | (kseg0_uncached & (req_vaddr[31:29] == 3'b100));
    end

    always_comb begin
        hit_res          = '0;
        hit_res.vaddr    = req_vaddr;
        hit_res.paddr    = {lu_hit_entry.pfn, req_vaddr[PAGE_OFFSET_W-1:0]};
        hit_res.illegal  = req_illegal;
        hit_res.dirty    = DATA_CHANNEL & lu_hit_entry.dirty;
        hit_res.uncached = DATA_CHANNEL & (lu_hit_entry.cache == CACHE_UNCACHED);
    end

    always_comb begin
        refill_res         = '0;
        refill_res.vaddr   = pend_vaddr_q;
        refill_res.illegal = pend_illegal_q;
        if (refill_data.miss) begin
            refill_res.miss = 1'b1;
        end else if (!refill_data.valid) begin
            refill_res.invalid = 1'b1;
        end else begin
            refill_res.paddr    = {refill_data.pfn, pend_vaddr_q[PAGE_OFFSET_W-1:0]};
            refill_res.dirty    = DATA_CHANNEL & refill_data.dirty;
            refill_res.uncached = DATA_CHANNEL & (refill_data.cache == CACHE_UNCACHED);
        end
    end

    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.vpn   = pend_vaddr_q[31:PAGE_OFFSET_W];
        new_entry.asid  = asid;
        new_entry.glob  = refill_data.glob;
        new_entry.pfn   = refill_data.pfn;
        new_entry.dirty = refill_data.dirty;
        new_entry.cache = refill_data.cache;
    end

    // A flush seen at any point during the refill suppresses the install.
    assign install = (state_q == ST_REFILL) & refill_ack & ~refill_data.miss
                   & refill_data.valid & ~flush & ~pend_flushed_q;

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        pend_vaddr_d   = pend_vaddr_q;
        pend_illegal_d = pend_illegal_q;
        pend_flushed_d = pend_flushed_q;
        resp_valid_d   = 1'b0;
        resp_result_d  = resp_result_q;
        for (int i = 0; i < ENTRIES; i++) begin
            entries_d[i] = entries_q[i];
            if (flush) begin
                entries_d[i].valid = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_mapped) begin
                        resp_valid_d  = 1'b1;
                        resp_result_d = unmapped_res;
                    end else if (lookup_hit) begin
                        resp_valid_d  = 1'b1;
                        resp_result_d = hit_res;
                    end else begin
                        state_d        = ST_REFILL;
                        pend_vaddr_d   = req_vaddr;
                        pend_illegal_d = req_illegal;
                        pend_flushed_d = 1'b0;
                    end
                end
            end
            ST_REFILL: begin
                if (flush) begin
                    pend_flushed_d = 1'b1;
                end
                if (refill_ack) begin
                    state_d       = ST_RESP;
                    resp_valid_d  = 1'b1;
                    resp_result_d = refill_res;
                end
                if (install) begin
                    entries_d[rr_q] = new_entry;
                    rr_d = (rr_q == IDX_W'(ENTRIES - 1)) ? '0 : rr_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            rr_q           <= '0;
            pend_vaddr_q   <= '0;
            pend_illegal_q <= 1'b0;
            pend_flushed_q <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_result_q  <= '0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            pend_vaddr_q   <= pend_vaddr_d;
            pend_illegal_q <= pend_illegal_d;
            pend_flushed_q <= pend_flushed_d;
            resp_valid_q   <= resp_valid_d;
            resp_result_q  <= resp_result_d;
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entries_q[gi] <= '0;
                end else begin
                    entries_q[gi] <= entries_d[gi];
                end
            end
        end
    endgenerate

    assign req_ready   = (state_q == ST_IDLE);
    assign refill_req  = (state_q == ST_REFILL);
    assign refill_vpn  = refill_req ? pend_vaddr_q[31:PAGE_OFFSET_W] : '0;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;

`ifdef MMU_UTLB_PERF_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        hit_event, miss_event;

    assign hit_event  = req_ready & req_valid & req_mapped & lookup_hit;
    assign miss_event = req_ready & req_valid & req_mapped & ~lookup_hit;

    always_comb begin
        hit_count_d  = hit_count_q + {31'd0, hit_event};
        miss_count_d = miss_count_q + {31'd0, miss_event};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_mmu_utlb.sv
// Self-checking bench for mmu_utlb (ENTRIES=4, data channel): vector table plus scoreboard of responses.
module tb_mmu_utlb;
    import mmu_utlb_pkg::*;

    logic              clk;
    logic              rst;
    logic [7:0]        asid;
    logic              user_mode;
    logic              kseg0_uncached;
    logic              flush;
    logic              req_valid;
    logic [31:0]       req_vaddr;
    logic              req_ready;
    logic              resp_valid;
    mmuResult_t        resp_result;
    logic              refill_req;
    logic [VPN_W-1:0]  refill_vpn;
    logic              refill_ack;
    utlbRefill_t       refill_data;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    mmu_utlb #(.ENTRIES(4), .DATA_CHANNEL(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .asid           (asid),
        .user_mode      (user_mode),
        .kseg0_uncached (kseg0_uncached),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_vaddr      (req_vaddr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_result    (resp_result),
        .refill_req     (refill_req),
        .refill_vpn     (refill_vpn),
        .refill_ack     (refill_ack),
        .refill_data    (refill_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] vaddr;
        logic [7:0]  asid;
        logic        user;
        logic        k0unc;
        logic        flush_req;
        logic        flush_refill;
        logic        exp_refill;
        utlbRefill_t rd;
        logic [31:0] paddr;
        logic        miss;
        logic        invalid;
        logic        illegal;
        logic        dirty;
        logic        uncached;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    mmuResult_t exp_q[$];
    mmuResult_t mon_e;
    vec_t       vecs[26];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic utlbRefill_t mk_rd(input logic miss, input logic valid, input logic dirty,
                                          input logic glob, input logic [2:0] cache,
                                          input logic [19:0] pfn);
        utlbRefill_t r;
        r.miss = miss; r.valid = valid; r.dirty = dirty;
        r.glob = glob; r.cache = cache; r.pfn = pfn;
        return r;
    endfunction

    function automatic utlbRefill_t rd_ok(input logic [19:0] pfn);
        return mk_rd(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, pfn);
    endfunction

    function automatic vec_t mkv(input logic [31:0] vaddr, input logic [7:0] a, input logic user,
                                 input logic k0, input logic fr, input logic ff, input logic er,
                                 input utlbRefill_t rd, input logic [31:0] paddr, input logic m,
                                 input logic inv, input logic ill, input logic d, input logic u);
        vec_t v;
        v.vaddr = vaddr; v.asid = a; v.user = user; v.k0unc = k0;
        v.flush_req = fr; v.flush_refill = ff; v.exp_refill = er; v.rd = rd;
        v.paddr = paddr; v.miss = m; v.invalid = inv; v.illegal = ill;
        v.dirty = d; v.uncached = u;
        return v;
    endfunction

    // Scoreboard consumer: every resp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got vaddr %h expected no response", resp_result.vaddr);
            end else begin
                mon_e = exp_q.pop_front();
                $display("resp vaddr=%h paddr=%h m=%0b i=%0b il=%0b d=%0b u=%0b",
                         resp_result.vaddr, resp_result.paddr, resp_result.miss,
                         resp_result.invalid, resp_result.illegal, resp_result.dirty,
                         resp_result.uncached);
                chk("resp_result", 96'(resp_result), 96'(mon_e));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        mmuResult_t e;
        @(negedge clk);
        asid           = v.asid;
        user_mode      = v.user;
        kseg0_uncached = v.k0unc;
        flush          = v.flush_req;
        req_valid      = 1'b1;
        req_vaddr      = v.vaddr;
        chk("req_ready_idle", 96'(req_ready), 96'(1));
        e.vaddr = v.vaddr; e.paddr = v.paddr; e.miss = v.miss; e.invalid = v.invalid;
        e.illegal = v.illegal; e.dirty = v.dirty; e.uncached = v.uncached;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("refill_req_T+1", 96'(refill_req), 96'(v.exp_refill));
        if (v.exp_refill) begin
            chk("refill_vpn", 96'(refill_vpn), 96'(v.vaddr[31:12]));
            chk("no_resp_in_refill", 96'(resp_valid), 96'(0));
            if (v.flush_refill) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                chk("refill_held", 96'(refill_req), 96'(1));
            end
            refill_ack  = 1'b1;
            refill_data = v.rd;
            @(negedge clk);
            refill_ack  = 1'b0;
            refill_data = '0;
            chk("resp_valid_A+1", 96'(resp_valid), 96'(1));
            chk("req_ready_A+1", 96'(req_ready), 96'(0));
            @(negedge clk);
            chk("resp_pulse_end", 96'(resp_valid), 96'(0));
            chk("req_ready_A+2", 96'(req_ready), 96'(1));
        end else begin
            chk("resp_valid_T+1", 96'(resp_valid), 96'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 1'b0; rst = 1'b0; asid = 8'd5; user_mode = 1'b0; kseg0_uncached = 1'b0;
        flush = 1'b0; req_valid = 1'b0; req_vaddr = '0; refill_ack = 1'b0; refill_data = '0;

        vecs[0]  = mkv(32'hBFC0_0000, 8'd5, 0, 0, 0, 0, 0, '0, 32'h1FC0_0000, 0, 0, 0, 1, 1);
        vecs[1]  = mkv(32'h8000_1000, 8'd5, 0, 0, 0, 0, 0, '0, 32'h0000_1000, 0, 0, 0, 1, 0);
        vecs[2]  = mkv(32'h8000_1000, 8'd5, 0, 1, 0, 0, 0, '0, 32'h0000_1000, 0, 0, 0, 1, 1);
        vecs[3]  = mkv(32'h8000_0000, 8'd5, 1, 0, 0, 0, 0, '0, 32'h0000_0000, 0, 0, 1, 1, 0);
        vecs[4]  = mkv(32'h0040_1234, 8'd5, 0, 0, 0, 0, 1, rd_ok(20'h12345), 32'h1234_5234, 0, 0, 0, 1, 0);
        vecs[5]  = mkv(32'h0040_1234, 8'd5, 0, 0, 0, 0, 0, '0, 32'h1234_5234, 0, 0, 0, 1, 0);
        vecs[6]  = mkv(32'h0040_1ABC, 8'd5, 0, 0, 0, 0, 0, '0, 32'h1234_5ABC, 0, 0, 0, 1, 0);
        vecs[7]  = mkv(32'h0050_0000, 8'd5, 0, 0, 0, 0, 1, mk_rd(1, 0, 0, 0, 3'd0, 20'h0), 32'h0, 1, 0, 0, 0, 0);
        vecs[8]  = mkv(32'h0050_0000, 8'd5, 0, 0, 0, 0, 1, mk_rd(0, 0, 0, 0, 3'd0, 20'h0), 32'h0, 0, 1, 0, 0, 0);
        vecs[9]  = mkv(32'h0050_0000, 8'd5, 0, 0, 0, 0, 1, mk_rd(0, 1, 0, 0, 3'd2, 20'h00ABC), 32'h00AB_C000, 0, 0, 0, 0, 1);
        vecs[10] = mkv(32'h0050_0004, 8'd5, 0, 0, 0, 0, 0, '0, 32'h00AB_C004, 0, 0, 0, 0, 1);
        vecs[11] = mkv(32'hC000_2000, 8'd6, 0, 0, 0, 0, 1, mk_rd(0, 1, 1, 1, 3'd3, 20'h22222), 32'h2222_2000, 0, 0, 0, 1, 0);
        vecs[12] = mkv(32'hC000_2010, 8'd7, 0, 0, 0, 0, 0, '0, 32'h2222_2010, 0, 0, 0, 1, 0);
        vecs[13] = mkv(32'h0040_1234, 8'd6, 0, 0, 0, 0, 1, rd_ok(20'h33333), 32'h3333_3234, 0, 0, 0, 1, 0);
        vecs[14] = mkv(32'h0060_0000, 8'd5, 0, 0, 0, 0, 1, rd_ok(20'h44444), 32'h4444_4000, 0, 0, 0, 1, 0);
        vecs[15] = mkv(32'h0040_1234, 8'd5, 0, 0, 0, 0, 1, rd_ok(20'h55555), 32'h5555_5234, 0, 0, 0, 1, 0);
        vecs[16] = mkv(32'h0040_1234, 8'd5, 0, 0, 1, 0, 1, rd_ok(20'h66666), 32'h6666_6234, 0, 0, 0, 1, 0);
        vecs[17] = mkv(32'h0040_1238, 8'd5, 0, 0, 0, 0, 0, '0, 32'h6666_6238, 0, 0, 0, 1, 0);
        vecs[18] = mkv(32'h0070_0000, 8'd5, 0, 0, 0, 1, 1, rd_ok(20'h77777), 32'h7777_7000, 0, 0, 0, 1, 0);
        vecs[19] = mkv(32'h0070_0000, 8'd5, 0, 0, 0, 0, 1, rd_ok(20'h77777), 32'h7777_7000, 0, 0, 0, 1, 0);
        vecs[20] = mkv(32'h0040_1234, 8'd5, 0, 0, 0, 0, 1, rd_ok(20'h12345), 32'h1234_5234, 0, 0, 0, 1, 0);
        vecs[21] = mkv(32'h0010_0000, 8'd5, 0, 0, 0, 0, 1, rd_ok(20'h0A0A0), 32'h0A0A_0000, 0, 0, 0, 1, 0);
        vecs[22] = mkv(32'h0010_0004, 8'd5, 0, 0, 0, 0, 0, '0, 32'h0A0A_0004, 0, 0, 0, 1, 0);
        vecs[23] = mkv(32'h0010_0008, 8'd5, 0, 0, 0, 0, 0, '0, 32'h0A0A_0008, 0, 0, 0, 1, 0);
        vecs[24] = mkv(32'h0020_0000, 8'd5, 0, 0, 0, 0, 1, rd_ok(20'h0B0B0), 32'h0B0B_0000, 0, 0, 0, 1, 0);
        vecs[25] = mkv(32'h0020_0FFF, 8'd5, 0, 0, 0, 0, 0, '0, 32'h0B0B_0FFF, 0, 0, 0, 1, 0);

        #12;
        chk("rst_req_ready",   96'(req_ready),   96'(1));
        chk("rst_resp_valid",  96'(resp_valid),  96'(0));
        chk("rst_resp_result", 96'(resp_result), 96'(0));
        chk("rst_refill_req",  96'(refill_req),  96'(0));
        chk("rst_refill_vpn",  96'(refill_vpn),  96'(0));
        chk("rst_hit_count",   96'(hit_count),   96'(0));
        chk("rst_miss_count",  96'(miss_count),  96'(0));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i <= 20; i++) begin
            $display("vec %0d vaddr=%h asid=%0d", i, vecs[i].vaddr, vecs[i].asid);
            run_vec(vecs[i]);
        end
        @(negedge clk);
`ifdef MMU_UTLB_PERF_EN
        chk("hit_count_a",  96'(hit_count),  96'(5));
        chk("miss_count_a", 96'(miss_count), 96'(12));
`else
        chk("hit_count_a",  96'(hit_count),  96'(0));
        chk("miss_count_a", 96'(miss_count), 96'(0));
`endif

        // An ack while idle must be ignored.
        refill_ack  = 1'b1;
        refill_data = rd_ok(20'h99999);
        @(negedge clk);
        refill_ack  = 1'b0;
        refill_data = '0;
        chk("stray_ack_no_resp", 96'(resp_valid), 96'(0));
        chk("stray_ack_ready",   96'(req_ready),  96'(1));
        $display("stray ack idle: resp_valid=%0b req_ready=%0b", resp_valid, req_ready);

        // Reset in the middle of a refill aborts it with no response.
        req_valid = 1'b1;
        req_vaddr = 32'h0090_0000;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_refill_req_up", 96'(refill_req), 96'(1));
        #2 rst = 1'b0;
        #1;
        chk("abort_refill_req_drop", 96'(refill_req), 96'(0));
        chk("abort_req_ready",       96'(req_ready),  96'(1));
        chk("abort_hit_count",       96'(hit_count),  96'(0));
        chk("abort_miss_count",      96'(miss_count), 96'(0));
        $display("reset mid-refill: refill_req=%0b req_ready=%0b", refill_req, req_ready);
        @(negedge clk);
        rst = 1'b1;
        refill_ack  = 1'b1;
        refill_data = rd_ok(20'h99999);
        @(negedge clk);
        refill_ack  = 1'b0;
        refill_data = '0;
        chk("abort_no_resp", 96'(resp_valid), 96'(0));

        for (int i = 21; i <= 25; i++) begin
            $display("vec %0d vaddr=%h asid=%0d", i, vecs[i].vaddr, vecs[i].asid);
            run_vec(vecs[i]);
        end
        @(negedge clk);
`ifdef MMU_UTLB_PERF_EN
        chk("hit_count_b",  96'(hit_count),  96'(3));
        chk("miss_count_b", 96'(miss_count), 96'(2));
`else
        chk("hit_count_b",  96'(hit_count),  96'(0));
        chk("miss_count_b", 96'(miss_count), 96'(0));
`endif
        @(negedge clk);
        chk("scoreboard_empty", 96'(exp_q.size()), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
